// File: rtl/fir_pkg.sv
// Shared widths, default tap count and controller state encoding for the
// FIR tap-multiplier slice.
package fir_pkg;

    localparam int TAPS_DEFAULT = 401;
    localparam int SAMPLE_BITS  = 16;
    localparam int MULTBITS     = 2 * SAMPLE_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } fir_state_e;

    // Counter width for an index over n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient storage with a sequential write index; c[0] is written first.
// last_o flags that the current index is the final tap.
module fir_coef_bank #(
    parameter int TAPS        = fir_pkg::TAPS_DEFAULT,
    parameter int SAMPLE_BITS = fir_pkg::SAMPLE_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          restart_i,
    input  logic                          wr_en_i,
    input  logic signed [SAMPLE_BITS-1:0] wr_data_i,
    output logic                          last_o,
    output logic signed [SAMPLE_BITS-1:0] coef_o [0:TAPS-1]
);
    import fir_pkg::*;

    localparam int IDX_W = idx_width(TAPS);

    logic [IDX_W-1:0]              idx_q, idx_d;
    logic signed [SAMPLE_BITS-1:0] coef_q [0:TAPS-1];

    assign last_o = (idx_q == IDX_W'(TAPS - 1));

    // A restart wins over a write presented in the same cycle.
    always_comb begin
        idx_d = idx_q;
        if (restart_i) begin
            idx_d = '0;
        end else if (wr_en_i) begin
            idx_d = last_o ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= '0;
            end
        end else if (wr_en_i && !restart_i) begin
            coef_q[idx_q] <= wr_data_i;
        end
    end

    assign coef_o = coef_q;

endmodule

// File: rtl/fir_tap_multiplier.sv
// Per-tap Q1.15 multiplier stage of a direct-form FIR: sample delay line,
// registered full-precision products and the coefficient-load controller.
//
// state | meaning
// IDLE  | out of reset, nothing loaded, samples and coefficients ignored
// LOAD  | coefficient words written in order, c[0] first
// RUN   | samples accepted, one product strobe per accepted sample
module fir_tap_multiplier #(
    parameter int TAPS        = fir_pkg::TAPS_DEFAULT,
    parameter int SAMPLE_BITS = fir_pkg::SAMPLE_BITS,
    parameter int MULTBITS    = fir_pkg::MULTBITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic signed [SAMPLE_BITS-1:0] in_sample,
    output logic                          in_ready,
    input  logic                          coef_load,
    input  logic                          coef_valid,
    input  logic signed [SAMPLE_BITS-1:0] coef_data,
    output logic                          coef_ready,
    input  logic                          flush,
    output logic signed [MULTBITS-1:0]    multiplier_out [0:TAPS-1],
    output logic                          out_valid
);
    import fir_pkg::*;

    fir_state_e state_q, state_d;

    logic accept;
    logic clear_line;
    logic coef_wr;
    logic coef_last;

    logic signed [SAMPLE_BITS-1:0] coef [0:TAPS-1];
    logic signed [SAMPLE_BITS-1:0] x_q  [0:TAPS-1];
    logic signed [MULTBITS-1:0]    prod_q [0:TAPS-1];
    logic                          acc_q;
    logic                          out_valid_q;

    assign in_ready   = (state_q == ST_RUN);
    assign coef_ready = (state_q == ST_LOAD);

    // coef_load outranks flush; both empty the delay line and drop the sample.
    assign clear_line = coef_load || flush;
    assign accept     = in_valid && in_ready && !clear_line;
    assign coef_wr    = coef_ready && coef_valid && !coef_load;

    fir_coef_bank #(
        .TAPS        (TAPS),
        .SAMPLE_BITS (SAMPLE_BITS)
    ) u_coef_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (coef_load),
        .wr_en_i   (coef_wr),
        .wr_data_i (coef_data),
        .last_o    (coef_last),
        .coef_o    (coef)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (coef_load) state_d = ST_LOAD;
            ST_LOAD: if (coef_wr && coef_last) state_d = ST_RUN;
            ST_RUN:  if (coef_load) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
        end else if (clear_line) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
        end else if (accept) begin
            x_q[0] <= in_sample;
            for (int k = 1; k < TAPS; k++) begin
                x_q[k] <= x_q[k-1];
            end
        end
    end

    // acc_q marks a freshly shifted delay line; products follow one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= accept;
            out_valid_q <= acc_q && !clear_line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= '0;
            end
        end else if (acc_q && !clear_line) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= MULTBITS'(x_q[k]) * MULTBITS'(coef[k]);
            end
        end
    end

    assign multiplier_out = prod_q;
    assign out_valid      = out_valid_q;

endmodule

// File: tb/tb_fir_tap_multiplier.sv
// Directed bench for fir_tap_multiplier with a 5-tap instance; inputs change
// and outputs are sampled on the falling clock edge.
module tb_fir_tap_multiplier;

    localparam int TAPS = 5;
    localparam int SB   = 16;
    localparam int MB   = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [SB-1:0] in_sample = '0;
    logic                 in_ready;
    logic                 coef_load = 1'b0;
    logic                 coef_valid = 1'b0;
    logic signed [SB-1:0] coef_data = '0;
    logic                 coef_ready;
    logic                 flush = 1'b0;
    logic signed [MB-1:0] mo [0:TAPS-1];
    logic                 out_valid;

    int checks = 0;
    int errors = 0;

    logic [SB-1:0] cw [0:TAPS-1];

    always #5 clk = ~clk;

    fir_tap_multiplier #(.TAPS(TAPS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_sample      (in_sample),
        .in_ready       (in_ready),
        .coef_load      (coef_load),
        .coef_valid     (coef_valid),
        .coef_data      (coef_data),
        .coef_ready     (coef_ready),
        .flush          (flush),
        .multiplier_out (mo),
        .out_valid      (out_valid)
    );

    // Stimulus driver only: pulse coef_load then write cw[0..TAPS-1].
    task automatic load_coefs();
        coef_load = 1'b1;
        @(negedge clk);
        coef_load = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            coef_valid = 1'b1;
            coef_data  = cw[i];
            @(negedge clk);
        end
        coef_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL reset_coef_ready: got %b expected 0", coef_ready); end
        for (int k = 0; k < TAPS; k++) begin
            checks++; if (mo[k] !== 32'sd0) begin errors++; $display("FAIL reset_mo[%0d]: got %h expected 0", k, mo[k]); end
        end
        rst_n = 1'b1;
        in_valid = 1'b1; in_sample = 16'h0123;
        coef_valid = 1'b1; coef_data = 16'h0456;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0; coef_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_basic_load();
        cw = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        coef_load = 1'b1;
        @(negedge clk);
        coef_load = 1'b0;
        checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL load_coef_ready: got %b expected 1", coef_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_in_ready: got %b expected 0", in_ready); end
        for (int i = 0; i < TAPS; i++) begin
            coef_valid = 1'b1; coef_data = cw[i];
            @(negedge clk);
        end
        coef_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready: got %b expected 1", in_ready); end
        checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL run_coef_ready: got %b expected 0", coef_ready); end

        in_valid = 1'b1; in_sample = 16'h1000;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid1: got %b expected 1", out_valid); end
        checks++; if (mo[0] !== 32'sh04000000) begin errors++; $display("FAIL basic_mo0_a: got %h expected 04000000", mo[0]); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_strobe_width: got %b expected 0", out_valid); end
        checks++; if (mo[0] !== 32'sh04000000) begin errors++; $display("FAIL basic_hold: got %h expected 04000000", mo[0]); end

        in_valid = 1'b1; in_sample = 16'h2000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid2: got %b expected 1", out_valid); end
        checks++; if (mo[0] !== 32'sh08000000) begin errors++; $display("FAIL basic_mo0_b: got %h expected 08000000", mo[0]); end
        checks++; if (mo[1] !== 32'sh00000000) begin errors++; $display("FAIL basic_mo1_b: got %h expected 00000000", mo[1]); end
    endtask

    task automatic test_neg_full_scale();
        cw = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        load_coefs();
        for (int i = 0; i < TAPS; i++) begin
            in_valid = 1'b1; in_sample = 16'h8000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL negfs_valid: got %b expected 1", out_valid); end
        for (int k = 0; k < TAPS; k++) begin
            checks++; if (mo[k] !== 32'sh40000000) begin errors++; $display("FAIL negfs_mo[%0d]: got %h expected 40000000", k, mo[k]); end
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_sample = 16'h0200;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_inflight: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_inflight2: got %b expected 0", out_valid); end

        flush = 1'b1; in_valid = 1'b1; in_sample = 16'h1234;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got %b expected 1", in_ready); end

        in_valid = 1'b1; in_sample = 16'h0100;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid: got %b expected 1", out_valid); end
        checks++; if (mo[0] !== 32'shFF800000) begin errors++; $display("FAIL flush_mo0: got %h expected ff800000", mo[0]); end
        for (int k = 1; k < TAPS; k++) begin
            checks++; if (mo[k] !== 32'sd0) begin errors++; $display("FAIL flush_mo[%0d]: got %h expected 0", k, mo[k]); end
        end
    endtask

    task automatic test_reload();
        cw = '{16'h0001, 16'hFFFE, 16'h0003, 16'hFFFC, 16'h0005};
        in_valid = 1'b1; in_sample = 16'h3333;
        coef_load = 1'b1;
        @(negedge clk);
        coef_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            coef_valid = 1'b1; coef_data = 16'h7777;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reload_partial_in_ready[%0d]: got %b expected 0", i, in_ready); end
            @(negedge clk);
        end
        coef_valid = 1'b0; coef_load = 1'b1;
        @(negedge clk);
        coef_load = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            coef_valid = 1'b1; coef_data = cw[i];
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reload_in_ready[%0d]: got %b expected 0", i, in_ready); end
            @(negedge clk);
        end
        coef_valid = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reload_run: got %b expected 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic signed [MB-1:0] e [0:TAPS-1];
        int n_valid;
        int first_i;
        int last_i;
        e = '{32'sd10, -32'sd18, 32'sd24, -32'sd28, 32'sd30};
        n_valid = 0; first_i = -1; last_i = -1;
        coef_valid = 1'b1; coef_data = 16'h1111;
        for (int i = 0; i < 14; i++) begin
            if (i < 10) begin
                in_valid = 1'b1; in_sample = SB'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid === 1'b1) begin
                n_valid++;
                if (first_i < 0) first_i = i;
                last_i = i;
                checks++; if (mo[0] !== MB'(i)) begin errors++; $display("FAIL b2b_mo0_at_%0d: got %h expected %h", i, mo[0], MB'(i)); end
                if (i == 1) begin
                    checks++; if (mo[1] !== 32'sd0) begin errors++; $display("FAIL b2b_first_mo1: got %h expected 0", mo[1]); end
                end
            end
        end
        coef_valid = 1'b0;
        checks++; if (n_valid !== 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", n_valid); end
        checks++; if (first_i !== 1) begin errors++; $display("FAIL b2b_first: got %0d expected 1", first_i); end
        checks++; if (last_i - first_i !== 9) begin errors++; $display("FAIL b2b_contiguous: got span %0d expected 9", last_i - first_i); end
        for (int k = 0; k < TAPS; k++) begin
            checks++; if (mo[k] !== e[k]) begin errors++; $display("FAIL b2b_final_mo[%0d]: got %h expected %h", k, mo[k], e[k]); end
        end
    endtask

    task automatic test_reset_mid_run();
        in_valid = 1'b1; in_sample = 16'h0004;
        @(negedge clk);
        in_sample = 16'h0005;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_async_in_ready: got %b expected 0", in_ready); end
        checks++; if (mo[0] !== 32'sd0) begin errors++; $display("FAIL rst_async_mo0: got %h expected 0", mo[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_pending_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_idle_in_ready: got %b expected 0", in_ready); end

        coef_load = 1'b1;
        @(negedge clk);
        coef_load = 1'b0;
        coef_valid = 1'b1; coef_data = 16'h2222;
        @(negedge clk);
        @(negedge clk);
        coef_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL rst_load_abort: got %b expected 0", coef_ready); end

        cw = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        load_coefs();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_reload_run: got %b expected 1", in_ready); end
        in_valid = 1'b1; in_sample = 16'h7FFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (mo[0] !== 32'sh3FFF0001) begin errors++; $display("FAIL rst_reload_mo0: got %h expected 3fff0001", mo[0]); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_neg_full_scale();
        test_flush();
        test_reload();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
